cache_wb_dm: RTL and testbench
==============================

Name: cache_wb_dm

Overview:
Parametrised direct-mapped, write-back, write-allocate byte cache between the CPU and line-wide main memory. It is the successor to the single-cycle line cache and adds:
- valid/dirty tracking
- a req/ack memory handshake for line fill and eviction
- a CPU valid/ready interface

A CPU byte access hits in 2 cycles. On a miss the block stalls the CPU while it evicts the victim line (if dirty) and then fills the requested line.

Parameters:
ADDR_W, 32, CPU/memory byte-address width
LINE_BYTES, 128, bytes per line (power of 2; line = LINE_BYTES*8 bits, 1024 by default)
NUM_LINES, 8, number of lines (power of 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  CPU access request
cpu_we  in  1  1 = byte write, 0 = byte read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  8  write byte
cpu_ready  out  1  block can accept a request this cycle
cpu_done  out  1  one-cycle pulse: access complete
cpu_rdata  out  8  read byte, valid while cpu_done=1
cpu_hit  out  1  qualifies cpu_done: 1 = access was a hit
mem_req  out  1  memory transaction request
mem_we  out  1  1 = line write-back, 0 = line fill
mem_addr  out  ADDR_W  line-aligned address (offset bits zero)
mem_wline  out  LINE_BYTES*8  eviction data
mem_rline  in  LINE_BYTES*8  fill data, sampled on mem_ack
mem_ack  in  1  one-cycle completion pulse from memory

Behaviour:
- Address split:
  - OFF = $clog2(LINE_BYTES) low bits are the offset.
  - IDX = $clog2(NUM_LINES) next bits are the index.
  - The remaining bits are the tag.
  - Byte k of a line occupies bits [8k+7:8k].
- State machine: IDLE, LOOKUP, WB, FILL.
- cpu_ready = (state==IDLE) && rst_n. The request is accepted on the edge where cpu_req && cpu_ready. At that edge the block latches addr, we and wdata and moves to LOOKUP.
- LOOKUP, hit (valid[idx] && tag match):
  - Read: cpu_rdata = stored byte.
  - Write: the byte is written and dirty[idx] is set; cpu_rdata = the new byte.
  - cpu_done=1 and cpu_hit=1 (registered, so visible in the following cycle); next state IDLE.
  - Latency is 2 edges from acceptance. Back-to-back requests are allowed in the cycle cpu_done is high.
- LOOKUP, miss: valid && dirty → WB; otherwise → FILL.
- WB:
  - mem_req=1, mem_we=1, mem_addr={old tag, idx, 0}, mem_wline = stored line. All are held stable until mem_ack.
  - On mem_ack: dirty cleared, next state FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={new tag, idx, 0}, held stable until mem_ack.
  - On mem_ack the line is installed from mem_rline, merged with cpu_wdata at the offset on writes. Then tag is updated, valid=1, dirty=cpu_we.
  - cpu_rdata = resulting byte; cpu_done=1, cpu_hit=0; next state IDLE.
- mem_req deasserts the edge after mem_ack; transactions never overlap. mem_ack outside WB/FILL is ignored.
- cpu_req while cpu_ready=0 is ignored, and no state changes.
- cpu_done is low in all cycles except the completion pulse. cpu_rdata and cpu_hit hold their last value otherwise.
- Reset (rst_n=0 at an edge):
  - state=IDLE; all valid and dirty bits cleared.
  - cpu_done=0, cpu_hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wline=0.
  - Reset mid-WB/FILL abandons the transaction; mem_req is 0 from the next cycle. Line data arrays need no reset.

Optional Feature:
Macro CACHE_WB_STATS_EN.
- Defined: adds output ports hit_count [31:0] and miss_count [31:0].
  - They increment by 1 on each hit or miss completion (cpu_done edge), wrap at 2^32, and reset to 0.
  - Adds output evict_count [31:0], incremented on each WB mem_ack.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Cold read: reset, read 0x00000000, mem_rline byte0=0xA5 → mem_req with mem_we=0 and mem_addr=0x0; after ack cpu_done=1, cpu_hit=0, cpu_rdata=0xA5.
2. Hit timing: read 0x00000001 (byte1=0x5A in line) → cpu_done exactly 2 edges after acceptance, cpu_hit=1, rdata=0x5A, mem_req never asserts.
3. Write hit then read: write 0x00000005 data 0x77, then read 0x00000005 → both hit, rdata=0x77, no memory traffic.
4. Dirty eviction: after step 3, read 0x00000400 (same index 0, tag 1) → WB with mem_we=1, mem_addr=0x0, mem_wline byte5=0x77; then FILL with mem_addr=0x400; then cpu_done with cpu_hit=0.
5. Stall and reset: hold mem_ack low 10 cycles during FILL → mem_req and mem_addr stable, cpu_ready=0, extra cpu_req ignored. Assert rst_n=0 mid-FILL → mem_req=0 next cycle; a subsequent read of 0x0 misses.
6. With CACHE_WB_STATS_EN: steps 1–4 → hit_count=3, miss_count=2, evict_count=1; after reset all are 0.

Source files
------------

// File: rtl/cache_wb_dm.sv
// Direct-mapped, write-back, write-allocate byte cache with a req/ack line interface to memory.
// Define CACHE_WB_STATS_EN to add hit/miss/eviction counters as extra output ports.
module cache_wb_dm #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 128,
  parameter int NUM_LINES  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [7:0]              cpu_wdata,
  output logic                    cpu_ready,
  output logic                    cpu_done,
  output logic [7:0]              cpu_rdata,
  output logic                    cpu_hit,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wline,
  input  logic [LINE_BYTES*8-1:0] mem_rline,
  input  logic                    mem_ack
`ifdef CACHE_WB_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             evict_count
`endif
);

  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF - IDX;
  localparam int LW    = LINE_BYTES * 8;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_e;

  state_e                 state_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   we_q;
  logic [7:0]             wdata_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [NUM_LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [LW-1:0]          data_q [NUM_LINES];

  logic [IDX-1:0]         idx_w;
  logic [TAG_W-1:0]       tag_w;
  logic [OFF-1:0]         off_w;
  logic [OFF+2:0]         bsel;
  logic [LW-1:0]          stored_line;
  logic [7:0]             stored_byte;
  logic [LW-1:0]          fill_line;
  logic [7:0]             fill_byte;
  logic                   hit;
  logic                   hit_wr;
  logic                   fill_done;
  logic                   wb_done;
  logic [ADDR_W-1:0]      wb_addr;
  logic [ADDR_W-1:0]      fill_addr;

  assign idx_w       = addr_q[OFF +: IDX];
  assign tag_w       = addr_q[ADDR_W-1 -: TAG_W];
  assign off_w       = addr_q[OFF-1:0];
  assign bsel        = {off_w, 3'b000};
  assign stored_line = data_q[idx_w];
  assign stored_byte = stored_line[bsel +: 8];
  assign hit         = valid_q[idx_w] && (tag_q[idx_w] == tag_w);
  assign wb_addr     = {tag_q[idx_w], idx_w, {OFF{1'b0}}};
  assign fill_addr   = {tag_w, idx_w, {OFF{1'b0}}};

  assign hit_wr    = rst_n && (state_q == LOOKUP) && hit && we_q;
  assign fill_done = rst_n && (state_q == FILL) && mem_req && mem_ack;
  assign wb_done   = rst_n && (state_q == WB) && mem_ack;

  assign cpu_ready = (state_q == IDLE) && rst_n;

  // A write miss allocates the fetched line with the CPU byte already merged in.
  always_comb begin
    fill_line = mem_rline;
    if (we_q) fill_line[bsel +: 8] = wdata_q;
  end
  assign fill_byte = fill_line[bsel +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      cpu_done  <= 1'b0;
      cpu_hit   <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wline <= '0;
    end else begin
      cpu_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_done  <= 1'b1;
            cpu_hit   <= 1'b1;
            cpu_rdata <= we_q ? wdata_q : stored_byte;
            if (we_q) dirty_q[idx_w] <= 1'b1;
            state_q   <= IDLE;
          end else if (valid_q[idx_w] && dirty_q[idx_w]) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wb_addr;
            mem_wline <= stored_line;
            state_q   <= WB;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= fill_addr;
            state_q  <= FILL;
          end
        end
        WB: begin
          // Drop req for one cycle so the fill is a separate transaction.
          if (mem_ack) begin
            dirty_q[idx_w] <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            state_q        <= FILL;
          end
        end
        FILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= fill_addr;
          end else if (mem_ack) begin
            mem_req        <= 1'b0;
            valid_q[idx_w] <= 1'b1;
            dirty_q[idx_w] <= we_q;
            cpu_done       <= 1'b1;
            cpu_hit        <= 1'b0;
            cpu_rdata      <= fill_byte;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line data and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (hit_wr) data_q[idx_w][bsel +: 8] <= wdata_q;
    if (fill_done) begin
      data_q[idx_w] <= fill_line;
      tag_q[idx_w]  <= tag_w;
    end
  end

`ifdef CACHE_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count   <= '0;
      miss_count  <= '0;
      evict_count <= '0;
    end else begin
      if ((state_q == LOOKUP) && hit) hit_count <= hit_count + 32'd1;
      if (fill_done) miss_count <= miss_count + 32'd1;
      if (wb_done) evict_count <= evict_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_wb_dm.sv
// Bench for cache_wb_dm: directed plan steps plus a random access stream checked against a
// flat memory-view model; a randomised-latency memory responder backs the line interface.
module tb_cache_wb_dm;
  localparam int AW = 32, LB = 128, NL = 8, LW = LB * 8, OFF = 7, IDX = 3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic          cpu_ready, cpu_done, cpu_hit, mem_req, mem_we;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wline, mem_rline;
  logic          mem_ack;
`ifdef CACHE_WB_STATS_EN
  logic [31:0]   hit_count, miss_count, evict_count;
`endif

  cache_wb_dm #(.ADDR_W(AW), .LINE_BYTES(LB), .NUM_LINES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wline(mem_wline), .mem_rline(mem_rline), .mem_ack(mem_ack)
`ifdef CACHE_WB_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .evict_count(evict_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  bit timed_out = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkline(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    bit shown;
    checks++;
    if (act !== exp) begin
      errors++;
      shown = 0;
      for (int k = 0; k < LB; k++)
        if (!shown && act[8*k +: 8] !== exp[8*k +: 8]) begin
          $display("FAIL %s: byte %0d got %02h expected %02h", nm, k, act[8*k +: 8], exp[8*k +: 8]);
          shown = 1;
        end
    end
  endtask

  // Backing store (what DRAM holds) and CPU view (what every byte must read as).
  logic [LW-1:0] dram [logic [31:0]];
  logic [LW-1:0] view [logic [31:0]];

  function automatic logic [LW-1:0] get_dram(logic [31:0] la);
    logic [LW-1:0] l;
    if (!dram.exists(la)) begin
      for (int i = 0; i < LW / 32; i++) l[32*i +: 32] = $urandom;
      dram[la] = l;
    end
    return dram[la];
  endfunction

  function automatic logic [LW-1:0] vline(logic [31:0] la);
    if (view.exists(la)) return view[la];
    return get_dram(la);
  endfunction

  // Which line each index currently holds (residency only; data lives in view).
  logic        mvalid [NL];
  logic        mdirty [NL];
  logic [31:0] mtag   [NL];

  typedef struct { logic [7:0] rdata; logic hit; int acc; } done_t;
  typedef struct { logic we; logic [31:0] addr; logic [LW-1:0] line; } mem_t;
  done_t doneq[$];
  mem_t  memq[$];

  task automatic model_accept(logic [31:0] a, logic we, logic [7:0] wd);
    logic [31:0]   la, tg;
    int            ix, bo;
    done_t         d;
    mem_t          m;
    logic [LW-1:0] ln;
    la = a & ~32'(LB - 1);
    ix = int'((a >> OFF) % NL);
    bo = int'(a % LB);
    tg = a >> (OFF + IDX);
    d.hit = mvalid[ix] && (mtag[ix] == tg);
    if (!d.hit) begin
      if (mvalid[ix] && mdirty[ix]) begin
        m.we   = 1'b1;
        m.addr = (mtag[ix] << (OFF + IDX)) | (32'(ix) << OFF);
        m.line = vline(m.addr);
        memq.push_back(m);
      end
      m.we = 1'b0; m.addr = la; m.line = '0;
      memq.push_back(m);
      mvalid[ix] = 1'b1; mtag[ix] = tg; mdirty[ix] = 1'b0;
    end
    ln = vline(la);
    if (we) begin
      ln[8*bo +: 8] = wd;
      view[la] = ln;
      mdirty[ix] = 1'b1;
    end
    d.rdata = ln[8*bo +: 8];
    d.acc   = cyc;
    doneq.push_back(d);
  endtask

  // Compare process: all DUT outputs sampled on the falling edge.
  logic          rst_prev = 1'b1, prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0]   prev_addr = '0;
  logic [LW-1:0] prev_wline = '0;

  always @(negedge clk) begin
    done_t d;
    mem_t  m;
    cyc++;
    if (!rst_prev) begin
      chk("rst_done", cpu_done, 0);
      chk("rst_hit", cpu_hit, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wline_zero", 32'(mem_wline == '0), 1);
    end
    rst_prev = rst_n;
    if (!rst_n) begin
      doneq.delete(); memq.delete(); view.delete();
      for (int i = 0; i < NL; i++) begin mvalid[i] = 1'b0; mdirty[i] = 1'b0; end
      prev_req = 1'b0; prev_ack = 1'b0;
    end else begin
      if (cpu_done) begin
        if (doneq.size() == 0) chk("done_unexpected", cpu_done, 0);
        else begin
          d = doneq.pop_front();
          chk("rdata", cpu_rdata, d.rdata);
          chk("hit", cpu_hit, d.hit);
          if (d.hit) chk("hit_latency", cyc - d.acc, 2);
          else chk("mem_txns_left", memq.size(), 0);
        end
      end
      chk("cpu_ready", cpu_ready, 32'(doneq.size() == 0));
      if (prev_req && !prev_ack) begin
        chk("mem_req_held", mem_req, 1);
        if (mem_req) begin
          chk("mem_addr_held", mem_addr, prev_addr);
          chk("mem_we_held", mem_we, prev_we);
          chkline("mem_wline_held", mem_wline, prev_wline);
        end
      end
      if (mem_req && (!prev_req || prev_ack)) begin
        if (memq.size() == 0) chk("mem_req_unexpected", mem_req, 0);
        else begin
          m = memq.pop_front();
          chk("mem_we", mem_we, m.we);
          chk("mem_addr", mem_addr, m.addr);
          if (m.we) chkline("mem_wline", mem_wline, m.line);
        end
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we;
      prev_addr = mem_addr; prev_wline = mem_wline;
      if (cpu_req && cpu_ready) model_accept(cpu_addr, cpu_we, cpu_wdata);
    end
  end

  // Memory responder: random 0-3 cycle latency, stalls while hold_ack is set.
  bit            hold_ack = 0;
  int            mem_txn = 0;
  logic [31:0]   last_wb_addr = '1, last_fill_addr = '1;
  logic [LW-1:0] last_wb_line = '0;

  initial begin
    int wc;
    wc = -1;
    mem_ack = 1'b0;
    mem_rline = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!rst_n || !mem_req) wc = -1;
      else if (!hold_ack) begin
        if (wc < 0) wc = $urandom_range(0, 3);
        if (wc == 0) begin
          mem_ack = 1'b1;
          mem_txn++;
          if (mem_we) begin
            dram[mem_addr] = mem_wline;
            last_wb_addr = mem_addr;
            last_wb_line = mem_wline;
          end else begin
            mem_rline = get_dram(mem_addr);
            last_fill_addr = mem_addr;
          end
          wc = -1;
        end else wc--;
      end
    end
  end

  task automatic issue(logic [31:0] a, logic we, logic [7:0] wd, bit hold);
    int n;
    n = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_wdata = wd;
    do begin @(negedge clk); n++; end while (!cpu_ready && n < 200);
    chk("accept", cpu_ready, 1);
    if (!cpu_ready) timed_out = 1;
    @(posedge clk); #1;
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic wait_done(output logic [7:0] rd, output logic h, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cpu_done && lat < 200);
    chk("done_seen", cpu_done, 1);
    rd = cpu_rdata;
    h  = cpu_hit;
  endtask

  initial begin
    logic [LW-1:0] l;
    logic [7:0]    rd, b400;
    logic          h;
    int            lat, n;
    l = get_dram(32'h0);
    l[7:0] = 8'hA5;
    l[15:8] = 8'h5A;
    dram[32'h0] = l;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold read miss
    issue(32'h0, 1'b0, 8'h00, 1'b0);
    wait_done(rd, h, lat);
    chk("t1_rdata", rd, 8'hA5);
    chk("t1_hit", h, 0);
    chk("t1_fill_addr", last_fill_addr, 32'h0);
    chk("t1_txn", mem_txn, 1);
    // Read hit timing
    issue(32'h1, 1'b0, 8'h00, 1'b0);
    wait_done(rd, h, lat);
    chk("t2_rdata", rd, 8'h5A);
    chk("t2_hit", h, 1);
    chk("t2_latency", lat, 2);
    chk("t2_txn", mem_txn, 1);
    // Write hit then read back
    issue(32'h5, 1'b1, 8'h77, 1'b0);
    wait_done(rd, h, lat);
    chk("t3w_rdata", rd, 8'h77);
    chk("t3w_hit", h, 1);
    issue(32'h5, 1'b0, 8'h00, 1'b0);
    wait_done(rd, h, lat);
    chk("t3r_rdata", rd, 8'h77);
    chk("t3r_hit", h, 1);
    chk("t3_txn", mem_txn, 1);
    // Dirty eviction of index 0
    issue(32'h400, 1'b0, 8'h00, 1'b0);
    wait_done(rd, h, lat);
    l = get_dram(32'h400);
    b400 = l[7:0];
    chk("t4_hit", h, 0);
    chk("t4_rdata", rd, b400);
    chk("t4_txn", mem_txn, 3);
    chk("t4_wb_addr", last_wb_addr, 32'h0);
    chk("t4_wb_byte5", last_wb_line[47:40], 8'h77);
    chk("t4_fill_addr", last_fill_addr, 32'h400);
`ifdef CACHE_WB_STATS_EN
    chk("t6_hits", hit_count, 3);
    chk("t6_misses", miss_count, 2);
    chk("t6_evicts", evict_count, 1);
`endif
    // Stalled fill, ignored request, reset mid-fill
    hold_ack = 1;
    issue(32'h800, 1'b0, 8'h00, 1'b0);
    cpu_req = 1'b1; cpu_addr = 32'h123; cpu_we = 1'b1; cpu_wdata = 8'hEE;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    chk("t5_req_up", mem_req, 1);
    repeat (10) begin
      @(negedge clk);
      chk("t5_req_stall", mem_req, 1);
      chk("t5_addr_stall", mem_addr, 32'h800);
      chk("t5_ready_stall", cpu_ready, 0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_req_after_rst", mem_req, 0);
`ifdef CACHE_WB_STATS_EN
    chk("t6_rst_hits", hit_count, 0);
    chk("t6_rst_misses", miss_count, 0);
    chk("t6_rst_evicts", evict_count, 0);
`endif
    hold_ack = 0;
    issue(32'h0, 1'b0, 8'h00, 1'b0);
    wait_done(rd, h, lat);
    chk("t5_post_rst_hit", h, 0);
    chk("t5_post_rst_rdata", rd, 8'hA5);

    // Random stream: request held high so acceptances land back-to-back
    for (int i = 0; i < 300 && !timed_out; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        cpu_req = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end
      issue((32'($urandom_range(0, 3)) << 10) | 32'($urandom_range(0, 1023)),
            1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    end
    cpu_req = 1'b0;
    n = 0;
    while (doneq.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain_left", doneq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
